crt_char_clk_gen_p: RTL and testbench

Parametrised successor of the VGA character-clock generator.
- Replaces the fixed 8/9/4-dot Johnson counter with a programmable binary dot counter (4..2^DOT_W dots per character).
- Replaces the fixed 1-of-2 / 1-of-4 decimation with power-of-two dividers, independently programmable for shift-load and CRT-read.
- Adds a parametrised pixel-panning delay line.
- Sits between the CRTC timing logic and the attribute serializer, with host-programmed configuration.

---
 rtl/crt_clk_pkg.sv | 30 +++
 rtl/crt_host_if.sv | 20 ++
 rtl/crt_pan_delay.sv | 29 ++
 rtl/crt_char_clk_gen.sv | 169 ++++++++++++++++
 tb/tb_crt_char_clk_gen_p.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/crt_clk_pkg.sv
// Shared constants for the parametrised character-clock generator:
// register offsets, divider-code handling and cfg_rd field layout.
package crt_clk_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [15:0] REG_DOTS = 16'd0;
  localparam logic [15:0] REG_DIV  = 16'd1;
  localparam logic [15:0] REG_PAN  = 16'd2;

  localparam int CODE_W     = 3;
  localparam int DIV_SH_LSB = 0;
  localparam int DIV_RD_LSB = 4;

  localparam int DOTS_MIN = 3;

  localparam int CFG_DOTS_LSB = 0;
  localparam int CFG_SH_LSB   = 4;
  localparam int CFG_RD_LSB   = 8;
  localparam int CFG_PAN_LSB  = 12;

  function automatic logic [CODE_W-1:0] sat_code(
    input logic [CODE_W-1:0] c,
    input int unsigned       mx
  );
    return (32'(c) > mx) ? CODE_W'(mx) : c;
  endfunction

endpackage

// File: rtl/crt_host_if.sv
// Host IO write bus plus config readback for the
// character-clock generator.
interface crt_host_if;
  import crt_clk_pkg::*;

  logic              h_io_wr;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_io_dbus;
  logic [DATA_W-1:0] cfg_rd;

  modport master (
    output h_io_wr, h_addr, h_io_dbus,
    input  cfg_rd
  );

  modport slave (
    input  h_io_wr, h_addr, h_io_dbus,
    output cfg_rd
  );
endinterface

// File: rtl/crt_pan_delay.sv
// Dot-rate delay line with selectable tap and registered output;
// tap 0 is the undelayed input.
module crt_pan_delay #(
  parameter int PAN_W = 4
) (
  input  logic             h_hclk,
  input  logic             h_reset_n,
  input  logic             clk_en,
  input  logic [PAN_W-1:0] sel,
  input  logic             din,
  output logic             dout
);
  localparam int DEPTH = (1 << PAN_W) - 1;

  logic [DEPTH-1:0] sr;
  logic [DEPTH:0]   tap;

  assign tap = {sr, din};

  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      sr   <= '0;
      dout <= 1'b0;
    end else if (clk_en) begin
      sr   <= tap[DEPTH-1:0];
      dout <= tap[sel];
    end
  end
endmodule

// File: rtl/crt_char_clk_gen.sv
// Programmable character clock with pow2 load/read dividers.
// Pixel panning delay lines built only with CRT_CHAR_CLK_PAN_EN.
module crt_char_clk_gen_p
  import crt_clk_pkg::*;
#(
  parameter logic [15:0] REG_BASE     = 16'h03E0,
  parameter int          DOT_W        = 4,
  parameter int          PAN_W        = 4,
  parameter int          DIV_LOG2_MAX = 3,
  parameter int          DOTS_DEF     = 7
) (
  input  logic       h_hclk,
  input  logic       h_reset_n,
  crt_host_if.slave  host,
  input  logic       dclk_en,
  input  logic       hde,
  input  logic       ade,
  input  logic       screen_off,
  input  logic       line_cmp,
  input  logic       pix_pan,
  output logic       cclk_en,
  output logic       final_sh_ld,
  output logic       final_crt_rd
);
  localparam int DIV_W = DIV_LOG2_MAX;
  localparam logic [15:0] A_DOTS = REG_BASE + REG_DOTS;
  localparam logic [15:0] A_DIV  = REG_BASE + REG_DIV;

  logic [DOT_W-1:0]  dots_m1, s_dots, dot_cnt, wr_dots;
  logic [CODE_W-1:0] sh_code, rd_code, s_sh, s_rd;
  logic [DIV_W-1:0]  sh_div, rd_div, sh_mask, rd_mask;
  logic              sel_dots, sel_div;
  logic              raw_ld, raw_rd, div_ld, div_rd;
  logic [15:0]       cfg;
  logic              unused;

  assign sel_dots = host.h_io_wr && (host.h_addr == A_DOTS);
  assign sel_div  = host.h_io_wr && (host.h_addr == A_DIV);
  assign wr_dots  = host.h_io_dbus[DOT_W-1:0];

  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      dots_m1 <= DOT_W'(DOTS_DEF);
      sh_code <= '0;
      rd_code <= '0;
    end else begin
      if (sel_dots)
        dots_m1 <= (wr_dots < DOT_W'(DOTS_MIN)) ?
                   DOT_W'(DOTS_MIN) : wr_dots;
      if (sel_div) begin
        sh_code <= sat_code(
          host.h_io_dbus[DIV_SH_LSB +: CODE_W], DIV_LOG2_MAX);
        rd_code <= sat_code(
          host.h_io_dbus[DIV_RD_LSB +: CODE_W], DIV_LOG2_MAX);
      end
    end
  end

  // shadows only move at a character boundary
  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      s_dots <= DOT_W'(DOTS_DEF);
      s_sh   <= '0;
      s_rd   <= '0;
    end else if (cclk_en) begin
      s_dots <= dots_m1;
      s_sh   <= sh_code;
      s_rd   <= rd_code;
    end
  end

  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n)
      dot_cnt <= '0;
    else if (dclk_en)
      dot_cnt <= cclk_en ? '0 : dot_cnt + DOT_W'(1);
  end

  assign cclk_en = dclk_en & (dot_cnt == s_dots);
  assign raw_ld  = cclk_en & ~screen_off;
  assign raw_rd  = cclk_en & ade & ~screen_off;
  assign sh_mask = DIV_W'((32'd1 << s_sh) - 32'd1);
  assign rd_mask = DIV_W'((32'd1 << s_rd) - 32'd1);

  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      sh_div <= '0;
      rd_div <= '0;
    end else if (!hde) begin
      sh_div <= '0;
      rd_div <= '0;
    end else begin
      if (raw_ld)
        sh_div <= (sh_div + DIV_W'(1)) & sh_mask;
      if (raw_rd)
        rd_div <= (rd_div + DIV_W'(1)) & rd_mask;
    end
  end

  assign div_ld = raw_ld & (sh_div == '0);
  assign div_rd = raw_rd & (rd_div == '0);

`ifdef CRT_CHAR_CLK_PAN_EN
  localparam logic [15:0] A_PAN = REG_BASE + REG_PAN;

  logic [PAN_W-1:0] pan, s_pan, eff_pan;
  logic             sel_pan;

  assign sel_pan = host.h_io_wr && (host.h_addr == A_PAN);

  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      pan   <= '0;
      s_pan <= '0;
    end else begin
      if (sel_pan)
        pan <= host.h_io_dbus[PAN_W-1:0];
      if (cclk_en)
        s_pan <= pan;
    end
  end

  assign eff_pan = (line_cmp & pix_pan) ? '0 : s_pan;

  crt_pan_delay #(.PAN_W(PAN_W)) u_ld_dly (
    .h_hclk    (h_hclk),
    .h_reset_n (h_reset_n),
    .clk_en    (dclk_en),
    .sel       (eff_pan),
    .din       (div_ld),
    .dout      (final_sh_ld)
  );

  crt_pan_delay #(.PAN_W(PAN_W)) u_rd_dly (
    .h_hclk    (h_hclk),
    .h_reset_n (h_reset_n),
    .clk_en    (dclk_en),
    .sel       (eff_pan),
    .din       (div_rd),
    .dout      (final_crt_rd)
  );

  assign unused = ^host.h_io_dbus[15:7];
`else
  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      final_sh_ld  <= 1'b0;
      final_crt_rd <= 1'b0;
    end else if (dclk_en) begin
      final_sh_ld  <= div_ld;
      final_crt_rd <= div_rd;
    end
  end

  assign unused = ^{host.h_io_dbus[15:7], line_cmp, pix_pan};
`endif

  always_comb begin
    cfg = '0;
    cfg[CFG_DOTS_LSB +: DOT_W] = dots_m1;
    cfg[CFG_SH_LSB +: CODE_W]  = sh_code;
    cfg[CFG_RD_LSB +: CODE_W]  = rd_code;
`ifdef CRT_CHAR_CLK_PAN_EN
    cfg[CFG_PAN_LSB +: PAN_W]  = pan;
`endif
  end

  assign host.cfg_rd = cfg;
endmodule

// File: tb/tb_crt_char_clk_gen_p.sv
// Randomised scoreboard bench for crt_char_clk_gen_p against a
// dot/character-level reference model.
module tb_crt_char_clk_gen_p;

  localparam logic [15:0] BASE = 16'h03E0;

  logic h_hclk = 1'b0;
  logic h_reset_n = 1'b0;
  logic dclk_en = 1'b0, hde = 1'b0, ade = 1'b0;
  logic screen_off = 1'b0, line_cmp = 1'b0, pix_pan = 1'b0;
  logic cclk_en, final_sh_ld, final_crt_rd;

  crt_host_if hif();

  crt_char_clk_gen_p dut (
    .h_hclk       (h_hclk),
    .h_reset_n    (h_reset_n),
    .host         (hif),
    .dclk_en      (dclk_en),
    .hde          (hde),
    .ade          (ade),
    .screen_off   (screen_off),
    .line_cmp     (line_cmp),
    .pix_pan      (pix_pan),
    .cclk_en      (cclk_en),
    .final_sh_ld  (final_sh_ld),
    .final_crt_rd (final_crt_rd)
  );

  always #5 h_hclk = ~h_hclk;

  typedef struct packed {
    logic        c;
    logic        l;
    logic        r;
    logic [15:0] cfg;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pct = 100;
  bit rnd = 0;
  bit c_hde = 1, c_ade = 1, c_soff = 0, c_lc = 0, c_pp = 0;

  // reference model state
  int r_dots, r_sh, r_rd, r_pan;
  int s_dots, s_sh, s_rd, s_pan;
  int pos, ph_l, ph_r;
  bit hl[$], hr[$];
  bit f_l, f_r;
  bit m_c, m_rawl, m_rawr, m_dl, m_dr;
  int m_eff;

  function automatic void m_reset();
    r_dots = 7; r_sh = 0; r_rd = 0; r_pan = 0;
    s_dots = 7; s_sh = 0; s_rd = 0; s_pan = 0;
    pos = 0; ph_l = 0; ph_r = 0;
    hl.delete(); hr.delete();
    f_l = 0; f_r = 0;
  endfunction

  function automatic void m_comb();
    m_c    = dclk_en && (pos == s_dots);
    m_rawl = m_c && !screen_off;
    m_rawr = m_rawl && ade;
    m_dl   = m_rawl && (ph_l == 0);
    m_dr   = m_rawr && (ph_r == 0);
    m_eff  = (line_cmp && pix_pan) ? 0 : s_pan;
  endfunction

  function automatic void m_edge();
    int k, d;
    if (dclk_en) begin
      hl.push_back(m_dl);
      hr.push_back(m_dr);
      k = hl.size() - 1;
      f_l = (k >= m_eff) ? hl[k - m_eff] : 1'b0;
      f_r = (k >= m_eff) ? hr[k - m_eff] : 1'b0;
      pos = m_c ? 0 : pos + 1;
    end
    if (!hde) begin
      ph_l = 0;
      ph_r = 0;
    end else begin
      if (m_rawl) ph_l = (ph_l + 1) % (1 << s_sh);
      if (m_rawr) ph_r = (ph_r + 1) % (1 << s_rd);
    end
    if (m_c) begin
      s_dots = r_dots; s_sh = r_sh; s_rd = r_rd; s_pan = r_pan;
    end
    if (hif.h_io_wr) begin
      if (hif.h_addr == BASE) begin
        d = int'(hif.h_io_dbus[3:0]);
        r_dots = (d < 3) ? 3 : d;
      end
      if (hif.h_addr == BASE + 16'd1) begin
        d = int'(hif.h_io_dbus[2:0]);
        r_sh = (d > 3) ? 3 : d;
        d = int'(hif.h_io_dbus[6:4]);
        r_rd = (d > 3) ? 3 : d;
      end
`ifdef CRT_CHAR_CLK_PAN_EN
      if (hif.h_addr == BASE + 16'd2)
        r_pan = int'(hif.h_io_dbus[3:0]);
`endif
    end
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.c = m_c;
    e.l = f_l;
    e.r = f_r;
    e.cfg = 16'((r_pan << 12) | (r_rd << 8) | (r_sh << 4) | r_dots);
    return e;
  endfunction

  // one h_hclk cycle: advance model over the edge, drive, predict
  task automatic step(input bit w, input logic [15:0] a,
                      input logic [15:0] d, input bit rst_v);
    @(posedge h_hclk);
    #1;
    cyc++;
    if (h_reset_n) m_edge();
    else m_reset();
    h_reset_n = rst_v;
    if (!rst_v) m_reset();
    if (rnd) begin
      if ($urandom_range(0, 99) < 3) c_hde = !c_hde;
      if ($urandom_range(0, 99) < 3) c_ade = !c_ade;
      if ($urandom_range(0, 99) < 2) c_soff = !c_soff;
      if ($urandom_range(0, 99) < 3) c_lc = !c_lc;
      if ($urandom_range(0, 99) < 3) c_pp = !c_pp;
    end
    dclk_en = ($urandom_range(0, 99) < pct);
    hde = c_hde; ade = c_ade; screen_off = c_soff;
    line_cmp = c_lc; pix_pan = c_pp;
    hif.h_io_wr = w;
    hif.h_addr = a;
    hif.h_io_dbus = d;
    m_comb();
    sb.push_back(m_out());
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 16'h0, 16'h0, 1);
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    step(1, BASE + 16'(off), d, 1);
  endtask

  always @(negedge h_hclk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({cclk_en, final_sh_ld, final_crt_rd, hif.cfg_rd} !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL cyc%0d outputs: got c=%b l=%b r=%b cfg=%h, want c=%b l=%b r=%b cfg=%h",
                   cyc, cclk_en, final_sh_ld, final_crt_rd, hif.cfg_rd,
                   e.c, e.l, e.r, e.cfg);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    hif.h_io_wr = 1'b0;
    hif.h_addr = '0;
    hif.h_io_dbus = '0;
    step(0, 16'h0, 16'h0, 0);
    step(0, 16'h0, 16'h0, 0);
    run(40);
    // dots per char: mid-character change, then clamp
    run(3);
    wr(0, 16'h0008);
    run(60);
    wr(0, 16'h0001);
    run(40);
    // shift-load divider with hde drop
    wr(1, 16'h0002);
    run(100);
    c_hde = 0;
    run(12);
    c_hde = 1;
    run(100);
    // panning and line-compare reset
    wr(1, 16'h0000);
    wr(2, 16'h0003);
    run(60);
    c_lc = 1; c_pp = 1;
    run(60);
    c_lc = 0; c_pp = 0;
    // suppression by ade and screen_off
    c_ade = 0;
    run(50);
    c_ade = 1; c_soff = 1;
    run(50);
    c_soff = 0;
    // randomised traffic
    rnd = 1;
    pct = 60;
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0)
        wr($urandom_range(0, 3), 16'($urandom));
      else
        run(1);
    end
    rnd = 0;
    pct = 100;
    c_hde = 1; c_ade = 1; c_soff = 0; c_lc = 0; c_pp = 0;
    // reset mid-character with panning active
    wr(0, 16'h0007);
    wr(1, 16'h0011);
    wr(2, 16'h0005);
    run(45);
    repeat (3) step(0, 16'h0, 16'h0, 0);
    run(40);
    repeat (2) @(negedge h_hclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
